mux_nx1_reg: RTL and testbench
==============================

# mux_nx1_reg

Parametrised N-input, WIDTH-bit registered selector with a single-entry valid/ready output stage. It is the pipelined successor of the combinational 4:1 datapath mux: it captures the selected operand into an output register so the multicycle datapath can stall or back-pressure a stage without the selected value changing. It also reports a wrapping transfer count and, optionally, a sticky flag for out-of-range selects.

## Interface
- WIDTH, 32, data width of every input and the output.
- NUM_IN, 4, number of inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy NUM_IN <= 2**SEL_W.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_flat  input  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input index, sampled with in_valid.
- in_valid  input  1  producer offers {in_flat, sel}.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  registered selected value.
- out_sel  output  SEL_W  registered select that produced out_data.
- out_valid  output  1  out_data/out_sel hold a pending item.
- out_ready  input  1  consumer takes the item this cycle.
- xfer_cnt  output  16  accepted-transfer count; wraps.
- err_clr  input  1  clears err_sticky.
- err_sticky  output  1  an out-of-range select was accepted since the last clear.

## Operation
- Accept happens when in_valid && in_ready. Drain happens when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational, so a full stage with out_ready=1 accepts and drains in the same cycle. No bubble.
- On accept:
  - out_data <= input[sel] if sel < NUM_IN, else 0.
  - out_sel <= sel.
  - out_valid <= 1.
  - xfer_cnt <= xfer_cnt + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
- On drain without accept: out_valid <= 0. out_data and out_sel hold their last values.
- With no accept: out_data and out_sel do not change, whatever happens on in_flat or sel (stall stability).
- in_valid with in_ready=0: nothing is captured. The producer must hold its values; the block has no other storage.
- Two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on accept+drain, or when neither occurs.
- Reset (async assert, any state, including mid-transfer):
  - out_valid=0, out_data=0, out_sel=0, xfer_cnt=0, err_sticky=0.
  - in_ready=1 follows combinationally.
  - A pending item is discarded.
- Reset deassertion is synchronised externally. The first accept can occur on the first clock edge after deassertion.

## Timing
- Latency is 1 cycle: an item accepted at edge n is visible on out_data/out_valid after edge n.
- Throughput is one item per cycle while out_ready=1.
- in_ready depends combinationally on out_valid and out_ready only, never on in_valid.
- xfer_cnt and err_sticky update on the same edge as the accept.

## Configuration
- Macro: MUX_SEL_CHECK_EN.
- Defined:
  - An accept with sel >= NUM_IN sets err_sticky on that edge.
  - err_clr=1 clears err_sticky on the next edge.
  - If err_clr and a new out-of-range accept occur in the same cycle, the set wins and err_sticky stays 1.
- Not defined:
  - err_sticky is tied to 0 and err_clr is ignored.
  - Out-of-range selects still capture 0 and still count in xfer_cnt.

## Test plan
- **Reset / basic select:** WIDTH=32, NUM_IN=4, inputs 0x11111111..0x44444444. Apply rst, then accept sel=2 with out_ready=1 → one cycle later out_data=0x33333333, out_sel=2, out_valid=1, xfer_cnt=1.
- **Back-pressure stall:**
  - Accept sel=1, hold out_ready=0 for 5 cycles while changing in_flat and sel → out_data stays 0x22222222 and in_ready=0 throughout.
  - Raise out_ready → drain; in_ready=1 the same cycle.
- **Full-rate streaming:** in_valid=1, out_ready=1, sel cycling 0,1,2,3 for 8 cycles → out_data follows the inputs with 1-cycle lag, no bubbles, xfer_cnt=8.
- **Out-of-range select:** NUM_IN=3, SEL_W=2, accept sel=3.
  - Both builds: out_data=0 and out_sel=3.
  - With MUX_SEL_CHECK_EN: err_sticky=1.
  - Pulse err_clr alone → err_sticky=0.
  - Pulse err_clr together with another sel=3 accept → err_sticky stays 1.
  - Without the macro: err_sticky=0 throughout.
- **Counter wrap:** preset xfer_cnt to 0xFFFE (continuous accepts or a force), accept 2 items → xfer_cnt=0x0000.
- **Reset mid-operation:** with FULL and out_ready=0, assert rst between clock edges → immediately out_valid=0, out_data=0, xfer_cnt=0, err_sticky=0, in_ready=1.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// N:1 registered selector feeding a one-entry valid/ready stage; 1-cycle latency, accepts while empty or draining.
// Optional macro MUX_SEL_CHECK_EN enables the sticky out-of-range select flag.
module mux_nx1_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_cnt,
  input  logic                    err_clr,
  output logic                    err_sticky
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              drain;
  logic              sel_hit;
  logic [WIDTH-1:0]  sel_data;

  assign in_ready = (state == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = (state == FULL) && out_ready;

  // Out-of-range selects match no input, leaving sel_data at zero and sel_hit low.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_flat[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= '0;
      xfer_cnt <= '0;
    end else if (accept) begin
      out_data <= sel_data;
      out_sel  <= sel;
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  // A new out-of-range accept outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (accept && !sel_hit) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`else
  logic unused_sel_chk;
  assign unused_sel_chk = err_clr ^ sel_hit;
  assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: a 4-input and a 3-input instance on shared stimulus, table vectors plus a reference model.
module tb_mux_nx1_reg;

`ifdef MUX_SEL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word [4];
  logic [31:0] base [4];
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [127:0] in_flat4;
  logic [95:0]  in_flat3;

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_data  [2];
  logic [1:0]  o_sel   [2];
  logic [15:0] o_cnt   [2];
  logic        o_err   [2];

  int nchecks = 0;
  int nerr = 0;

  // Reference model state, one entry per instance.
  bit          mv [2];
  logic [31:0] md [2];
  logic [1:0]  ms [2];
  int          mc [2];
  bit          me [2];
  int          nin [2] = '{4, 3};

  typedef struct {
    logic        in_valid;
    logic [1:0]  sel;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  assign in_flat4 = {word[3], word[2], word[1], word[0]};
  assign in_flat3 = {word[2], word[1], word[0]};

  mux_nx1_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_flat(in_flat4), .sel(sel), .in_valid(in_valid),
    .in_ready(o_ready[0]), .out_data(o_data[0]), .out_sel(o_sel[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready), .xfer_cnt(o_cnt[0]), .err_clr(err_clr), .err_sticky(o_err[0])
  );

  mux_nx1_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_flat(in_flat3), .sel(sel), .in_valid(in_valid),
    .in_ready(o_ready[1]), .out_data(o_data[1]), .out_sel(o_sel[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready), .xfer_cnt(o_cnt[1]), .err_clr(err_clr), .err_sticky(o_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; md[d] = '0; ms[d] = '0; mc[d] = 0; me[d] = 1'b0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid%0d", tag, d), o_valid[d], 0);
      chk($sformatf("%s_data%0d", tag, d), o_data[d], 0);
      chk($sformatf("%s_sel%0d", tag, d), o_sel[d], 0);
      chk($sformatf("%s_cnt%0d", tag, d), o_cnt[d], 0);
      chk($sformatf("%s_err%0d", tag, d), o_err[d], 0);
      chk($sformatf("%s_ready%0d", tag, d), o_ready[d], 1);
    end
  endtask

  // One clock: check in_ready before the edge, advance the model on the edge, check outputs after it.
  task automatic cycle(input bit do_chk);
    bit rdy, acc, oor;
    #2;
    if (do_chk) begin
      for (int d = 0; d < 2; d++)
        chk($sformatf("in_ready%0d", d), o_ready[d], !mv[d] || out_ready);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      rdy = !mv[d] || out_ready;
      acc = in_valid && rdy;
      oor = int'(sel) >= nin[d];
      if (acc) begin
        md[d] = oor ? 32'h0 : word[sel];
        ms[d] = sel;
        mv[d] = 1'b1;
        mc[d] = (mc[d] + 1) % 65536;
      end else if (mv[d] && out_ready) begin
        mv[d] = 1'b0;
      end
      if (CHECK) begin
        if (acc && oor) me[d] = 1'b1;
        else if (err_clr) me[d] = 1'b0;
      end
    end
    #1;
    if (do_chk) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("out_valid%0d", d), o_valid[d], mv[d]);
        chk($sformatf("out_data%0d", d), o_data[d], md[d]);
        chk($sformatf("out_sel%0d", d), o_sel[d], ms[d]);
        chk($sformatf("xfer_cnt%0d", d), o_cnt[d], mc[d]);
        chk($sformatf("err_sticky%0d", d), o_err[d], me[d]);
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    base[0] = 32'h11111111; base[1] = 32'h22222222;
    base[2] = 32'h33333333; base[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) word[i] = base[i];
    model_reset();

    // in_valid, sel, out_ready -> expected out_valid, out_data, out_sel, xfer_cnt (4-input instance)
    tbl[0] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h33333333, 2'd2, 16'd1};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h22222222, 2'd1, 16'd2};
    tbl[2] = '{1'b1, 2'd3, 1'b0, 1'b1, 32'h22222222, 2'd1, 16'd2};
    tbl[3] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h22222222, 2'd1, 16'd2};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h22222222, 2'd1, 16'd2};
    tbl[5] = '{1'b1, 2'd0, 1'b0, 1'b1, 32'h11111111, 2'd0, 16'd3};
    tbl[6] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h44444444, 2'd3, 16'd4};
    tbl[7] = '{1'b0, 2'd2, 1'b0, 1'b1, 32'h44444444, 2'd3, 16'd4};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].in_valid; sel = tbl[i].sel; out_ready = tbl[i].out_ready;
      cycle(1);
      chk($sformatf("tbl%0d_valid", i), o_valid[0], tbl[i].exp_valid);
      chk($sformatf("tbl%0d_data", i), o_data[0], tbl[i].exp_data);
      chk($sformatf("tbl%0d_sel", i), o_sel[0], tbl[i].exp_sel);
      chk($sformatf("tbl%0d_cnt", i), o_cnt[0], tbl[i].exp_cnt);
    end

    // Back-pressure stall: item must hold while inputs churn.
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(1);
    in_valid = 1'b1; sel = 2'd1; out_ready = 1'b0;
    cycle(1);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) word[k] = $urandom;
      sel = 2'($urandom_range(0, 3));
      cycle(1);
      chk("stall_data", o_data[0], 32'h22222222);
      chk("stall_ready", o_ready[0], 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("stall_release_ready", o_ready[0], 1);
    cycle(1);
    chk("stall_drained", o_valid[0], 0);
    for (int k = 0; k < 4; k++) word[k] = base[k];

    // Full-rate streaming from a clean reset.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; sel = 2'(i % 4);
      cycle(1);
      chk("stream_data", o_data[0], base[i % 4]);
      chk("stream_valid", o_valid[0], 1);
    end
    chk("stream_cnt", o_cnt[0], 8);

    // Out-of-range select on the 3-input instance.
    pulse_reset();
    in_valid = 1'b1; sel = 2'd3; out_ready = 1'b1;
    cycle(1);
    chk("oor_data", o_data[1], 0);
    chk("oor_sel", o_sel[1], 3);
    chk("oor_err", o_err[1], CHECK);
    chk("oor_in_range_err", o_err[0], 0);
    in_valid = 1'b0; err_clr = 1'b1;
    cycle(1);
    chk("oor_clr", o_err[1], 0);
    in_valid = 1'b1; sel = 2'd3; err_clr = 1'b1;
    cycle(1);
    chk("oor_set_wins", o_err[1], CHECK);
    err_clr = 1'b0;

    // Counter wrap via continuous accepts.
    pulse_reset();
    in_valid = 1'b1; out_ready = 1'b1; sel = 2'd0;
    for (int i = 0; i < 65534; i++) cycle(0);
    chk("wrap_pre", o_cnt[0], 16'hFFFE);
    cycle(1);
    chk("wrap_ffff", o_cnt[0], 16'hFFFF);
    cycle(1);
    chk("wrap_zero", o_cnt[0], 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) word[k] = $urandom;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      err_clr   = ($urandom_range(0, 7) == 0);
      cycle(1);
    end
    err_clr = 1'b0;

    // Reset asserted between edges while FULL and stalled.
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(1);
    in_valid = 1'b1; sel = 2'd3; out_ready = 1'b0;
    cycle(1);
    chk("midrst_full", o_valid[0], 1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    model_reset();
    #1;
    rst = 1'b0;
    in_valid = 1'b1; sel = 2'd2; out_ready = 1'b1;
    cycle(1);
    chk("post_rst_data", o_data[0], word[2]);
    chk("post_rst_cnt", o_cnt[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
